// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divider ramp scheduler: FSM state encoding,
// default channel geometry and the channel-index width helper.
package div_sched_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

  localparam int DEF_NCH      = 4;
  localparam int DEF_W        = 16;
  localparam int DEF_STEP_W   = 8;
  localparam int DEF_TICK_DIV = 50000;
  localparam int DEF_START_HP = 1000;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_ramp_scheduler_if.sv
// Configuration channel of the ramp scheduler: valid/ready handshake carrying
// channel index, target half-period and ramp step.
interface div_ramp_scheduler_if
  import div_sched_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int W      = DEF_W,
  parameter int STEP_W = DEF_STEP_W
);
  localparam int CHW = ch_idx_w(NCH);

  logic              cfg_valid;
  logic              cfg_ready;
  logic [CHW-1:0]    cfg_ch;
  logic [W-1:0]      cfg_target;
  logic [STEP_W-1:0] cfg_step;

  modport master (
    output cfg_valid, cfg_ch, cfg_target, cfg_step,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_target, cfg_step,
    output cfg_ready
  );

endinterface

// File: rtl/ramp_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter; tick is high for the one cycle the count
// sits at its last value, i.e. the cycle before it wraps.
module ramp_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);
  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/div_ramp_scheduler.sv
// Ramps the half-period of NCH clock dividers toward configured targets, one
// channel per cycle in a periodic sweep through a single shared step datapath.
module div_ramp_scheduler
  import div_sched_pkg::*;
#(
  parameter int NCH      = DEF_NCH,
  parameter int W        = DEF_W,
  parameter int STEP_W   = DEF_STEP_W,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int START_HP = DEF_START_HP
) (
  input  logic                 CLK,
  input  logic                 RST,
  div_ramp_scheduler_if.slave  cfg,
  output logic [NCH*W-1:0]     div_in,
  output logic [NCH-1:0]       div_rst,
  output logic [NCH-1:0]       at_target,
  output logic                 busy
);
  localparam int             CHW     = ch_idx_w(NCH);
  localparam logic [0:0]     IDLE    = ST_IDLE;
  localparam logic [0:0]     SWEEP   = ST_SWEEP;
  localparam logic [W-1:0]   START   = W'(START_HP);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  logic [0:0]        state;
  logic              sweep_pend;
  logic              rdy_en;
  logic              tick;
  logic              cfg_acc;
  logic [CHW-1:0]    idx;

  logic [W-1:0]      cur_q [NCH];
  logic [W-1:0]      tgt_q [NCH];
  logic [STEP_W-1:0] stp_q [NCH];

  logic [W-1:0]      cur_s;
  logic [W-1:0]      tgt_s;
  logic [STEP_W-1:0] stp_s;
  logic [W-1:0]      nxt_s;

  // Comparing the remaining distance against the step keeps both directions
  // free of wrap-around and lands exactly on the target.
  function automatic logic [W-1:0] ramp_next(input logic [W-1:0]      cur,
                                             input logic [W-1:0]      tgt,
                                             input logic [STEP_W-1:0] stp);
    logic [W-1:0] s;
    s = W'(stp);
    if (cur > tgt) return (stp == '0 || (cur - tgt) < s) ? tgt : cur - s;
    if (cur < tgt) return (stp == '0 || (tgt - cur) < s) ? tgt : cur + s;
    return cur;
  endfunction

  ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  assign cfg.cfg_ready = rdy_en & (state == IDLE) & ~sweep_pend;
  assign cfg_acc       = cfg.cfg_valid & cfg.cfg_ready;
  assign busy          = (state == SWEEP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      sweep_pend <= 1'b0;
      idx        <= '0;
      rdy_en     <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      // A tick landing on the sweep-entry cycle stays pending for a second sweep.
      if (tick) begin
        sweep_pend <= 1'b1;
      end else if (state == IDLE && sweep_pend) begin
        sweep_pend <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (sweep_pend) begin
            state <= SWEEP;
            idx   <= '0;
          end
        end
        default: begin
          idx <= idx + CHW'(1);
          if (idx == LAST_CH) state <= IDLE;
        end
      endcase
    end
  end

  // Shared step datapath, muxed by the channel being swept
  assign cur_s = cur_q[idx];
  assign tgt_s = tgt_q[idx];
  assign stp_s = stp_q[idx];
  assign nxt_s = ramp_next(cur_s, tgt_s, stp_s);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) begin
        cur_q[i] <= START;
        tgt_q[i] <= '0;
        stp_q[i] <= '0;
      end
      div_rst   <= '1;
      at_target <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        at_target[i] <= ~div_rst[i] & (cur_q[i] == tgt_q[i]);
      end
      if (busy && tgt_s != '0) begin
        cur_q[idx] <= nxt_s;
      end
      // Accepts never coincide with a sweep cycle, so the cur_q writes cannot collide.
      if (cfg_acc) begin
        tgt_q[cfg.cfg_ch] <= cfg.cfg_target;
        stp_q[cfg.cfg_ch] <= cfg.cfg_step;
        if (cfg.cfg_target == '0) begin
          div_rst[cfg.cfg_ch] <= 1'b1;
          cur_q[cfg.cfg_ch]   <= START;
        end else begin
          div_rst[cfg.cfg_ch] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign div_in[g*W +: W] = cur_q[g];
  end

endmodule

// File: tb/tb_div_ramp_scheduler.sv
// Bench for div_ramp_scheduler: directed scenarios plus randomized config
// traffic, all checked against a cycle-position reference model.
module tb_div_ramp_scheduler;
  localparam int NCH    = 4;
  localparam int W      = 16;
  localparam int STEP_W = 8;
  localparam int CHW    = 2;
  localparam int TD     = 20;
  localparam int START  = 1000;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [NCH*W-1:0] div_in;
  logic [NCH-1:0]   div_rst;
  logic [NCH-1:0]   at_target;
  logic             busy;

  div_ramp_scheduler_if #(.NCH(NCH), .W(W), .STEP_W(STEP_W)) cfg ();

  div_ramp_scheduler #(
    .NCH(NCH), .W(W), .STEP_W(STEP_W), .TICK_DIV(TD), .START_HP(START)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cfg       (cfg),
    .div_in    (div_in),
    .div_rst   (div_rst),
    .at_target (at_target),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: k = clock edges since reset release. The tick sits at
  // k%TD == TD-1, the next cycle is the pending cycle, and channel i is swept
  // in the cycle with k%TD == i+1.
  int k;
  int m_cur [NCH];
  int m_tgt [NCH];
  int m_stp [NCH];
  bit m_stop[NCH];
  bit m_at  [NCH];

  function automatic bit exp_busy();
    return (k >= TD) && (k % TD >= 1) && (k % TD <= NCH);
  endfunction

  function automatic bit exp_ready();
    return (k >= 1) && !((k >= TD) && (k % TD <= NCH));
  endfunction

  function automatic int dut_hp(input int i);
    return int'(div_in[i*W +: W]);
  endfunction

  task automatic reset_model();
    k = 0;
    for (int i = 0; i < NCH; i++) begin
      m_cur[i] = START; m_tgt[i] = 0; m_stp[i] = 0; m_stop[i] = 1'b1; m_at[i] = 1'b0;
    end
  endtask

  task automatic step();
    bit acc;
    bit nat[NCH];
    int ch;
    int nc;
    acc = cfg.cfg_valid && exp_ready();
    for (int i = 0; i < NCH; i++) nat[i] = !m_stop[i] && (m_cur[i] == m_tgt[i]);
    if (exp_busy()) begin
      ch = k % TD - 1;
      if (m_tgt[ch] != 0) begin
        nc = m_cur[ch];
        if (m_cur[ch] > m_tgt[ch]) begin
          nc = m_cur[ch] - m_stp[ch];
          if (m_stp[ch] == 0 || nc < m_tgt[ch]) nc = m_tgt[ch];
        end else if (m_cur[ch] < m_tgt[ch]) begin
          nc = m_cur[ch] + m_stp[ch];
          if (m_stp[ch] == 0 || nc > m_tgt[ch]) nc = m_tgt[ch];
        end
        m_cur[ch] = nc;
      end
    end
    if (acc) begin
      ch = int'(cfg.cfg_ch);
      m_tgt[ch] = int'(cfg.cfg_target);
      m_stp[ch] = int'(cfg.cfg_step);
      if (m_tgt[ch] == 0) begin
        m_stop[ch] = 1'b1; m_cur[ch] = START;
      end else begin
        m_stop[ch] = 1'b0;
      end
    end
    for (int i = 0; i < NCH; i++) m_at[i] = nat[i];
    @(posedge CLK);
    k++;
    @(negedge CLK);
  endtask

  task automatic adv_to(input int ph);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(k >= TD && k % TD == ph) && n < 4 * TD);
    if (n >= 4 * TD) begin
      n_checks++; n_fail++;
      $display("FAIL adv_to: phase %0d not reached, k=%0d", ph, k);
    end
  endtask

  task automatic cfg_write(input int ch, input int tgt, input int stp);
    bit acc;
    int n = 0;
    cfg.cfg_ch = CHW'(ch); cfg.cfg_target = W'(tgt); cfg.cfg_step = STEP_W'(stp);
    cfg.cfg_valid = 1'b1;
    do begin
      acc = exp_ready();
      step();
      n++;
    end while (!acc && n < 4 * TD);
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    cfg.cfg_valid = 1'b0; cfg.cfg_ch = '0; cfg.cfg_target = '0; cfg.cfg_step = '0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++; if (div_rst !== 4'hF) begin n_fail++; $display("FAIL reset_div_rst: got %h want f", div_rst); end
    n_checks++; if (at_target !== 4'h0) begin n_fail++; $display("FAIL reset_at_target: got %h want 0", at_target); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    for (int i = 0; i < NCH; i++) begin
      n_checks++;
      if (dut_hp(i) !== START) begin n_fail++; $display("FAIL reset_div_in[%0d]: got %0d want %0d", i, dut_hp(i), START); end
    end
    RST = 1'b0;
    reset_model();
    step();
    n_checks++; if (cfg.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b want 1", cfg.cfg_ready); end
  endtask

  task automatic test_jump();
    cfg_write(1, 100, 0);
    n_checks++; if (div_rst !== 4'b1101) begin n_fail++; $display("FAIL jump_div_rst: got %b want 1101", div_rst); end
    adv_to(2);
    n_checks++; if (dut_hp(1) !== START) begin n_fail++; $display("FAIL jump_before: got %0d want %0d", dut_hp(1), START); end
    step();
    n_checks++; if (dut_hp(1) !== 100) begin n_fail++; $display("FAIL jump_div_in: got %0d want 100", dut_hp(1)); end
    n_checks++; if (at_target[1] !== 1'b0) begin n_fail++; $display("FAIL jump_at_early: got %b want 0", at_target[1]); end
    step();
    n_checks++; if (at_target[1] !== 1'b1) begin n_fail++; $display("FAIL jump_at_target: got %b want 1", at_target[1]); end
  endtask

  task automatic test_ramp_down();
    cfg_write(0, 400, 100);
    for (int s = 1; s <= 6; s++) begin
      adv_to(2);
      n_checks++;
      if (dut_hp(0) !== START - 100 * s) begin n_fail++; $display("FAIL ramp_down sweep %0d: got %0d want %0d", s, dut_hp(0), START - 100 * s); end
      step();
      n_checks++;
      if (at_target[0] !== (s == 6)) begin n_fail++; $display("FAIL ramp_at sweep %0d: got %b want %b", s, at_target[0], s == 6); end
    end
  endtask

  task automatic test_saturate();
    int e;
    cfg_write(0, 450, 100);
    adv_to(2);
    n_checks++; if (dut_hp(0) !== 450) begin n_fail++; $display("FAIL sat_450: got %0d want 450", dut_hp(0)); end
    cfg_write(0, 65535, 255);
    for (int s = 1; s <= 256; s++) begin
      adv_to(2);
      e = (450 + 255 * s > 65535) ? 65535 : 450 + 255 * s;
      n_checks++;
      if (dut_hp(0) !== e) begin n_fail++; $display("FAIL sat_top sweep %0d: got %0d want %0d", s, dut_hp(0), e); end
    end
  endtask

  task automatic test_handshake();
    int n = 0;
    adv_to(0);
    cfg.cfg_ch = 2'd3; cfg.cfg_target = 16'd200; cfg.cfg_step = 8'd50; cfg.cfg_valid = 1'b1;
    while (!cfg.cfg_ready && n < 4 * TD) begin
      n++;
      step();
    end
    n_checks++; if (n !== NCH + 1) begin n_fail++; $display("FAIL hs_ready_low: got %0d cycles want %0d", n, NCH + 1); end
    step();
    cfg.cfg_valid = 1'b0;
    n_checks++; if (div_rst[3] !== 1'b0) begin n_fail++; $display("FAIL hs_accept: got div_rst[3]=%b want 0", div_rst[3]); end
    adv_to(TD - 1);
    n_checks++; if (cfg.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL hs_tick_ready: got %b want 1", cfg.cfg_ready); end
    cfg.cfg_ch = 2'd3; cfg.cfg_target = 16'd300; cfg.cfg_step = 8'd0; cfg.cfg_valid = 1'b1;
    step();
    cfg.cfg_valid = 1'b0;
    adv_to(NCH + 1);
    n_checks++; if (dut_hp(3) !== 300) begin n_fail++; $display("FAIL hs_tick_accept: got %0d want 300", dut_hp(3)); end
  endtask

  task automatic test_back_to_back();
    adv_to(NCH + 1);
    cfg.cfg_ch = 2'd0; cfg.cfg_target = 16'd700; cfg.cfg_step = 8'd0; cfg.cfg_valid = 1'b1;
    step();
    cfg.cfg_target = 16'd800;
    step();
    cfg.cfg_valid = 1'b0;
    adv_to(2);
    n_checks++; if (dut_hp(0) !== 800) begin n_fail++; $display("FAIL b2b_last_wins: got %0d want 800", dut_hp(0)); end
  endtask

  task automatic test_stop();
    cfg_write(2, 600, 0);
    adv_to(4);
    n_checks++; if (dut_hp(2) !== 600) begin n_fail++; $display("FAIL stop_running: got %0d want 600", dut_hp(2)); end
    cfg_write(2, 0, 0);
    n_checks++; if (div_rst[2] !== 1'b1) begin n_fail++; $display("FAIL stop_div_rst: got %b want 1", div_rst[2]); end
    n_checks++; if (dut_hp(2) !== START) begin n_fail++; $display("FAIL stop_div_in: got %0d want %0d", dut_hp(2), START); end
    adv_to(3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midsweep_busy: got %b want 1", busy); end
    RST = 1'b1;
    #1;
    n_checks++; if (div_rst !== 4'hF) begin n_fail++; $display("FAIL rst_mid_div_rst: got %h want f", div_rst); end
    n_checks++; if (at_target !== 4'h0) begin n_fail++; $display("FAIL rst_mid_at: got %h want 0", at_target); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    for (int i = 0; i < NCH; i++) begin
      n_checks++;
      if (dut_hp(i) !== START) begin n_fail++; $display("FAIL rst_mid_div_in[%0d]: got %0d want %0d", i, dut_hp(i), START); end
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    reset_model();
    step();
  endtask

  task automatic test_random();
    logic [NCH-1:0] e_rst;
    logic [NCH-1:0] e_at;
    int r;
    for (int c = 0; c < 900; c++) begin
      cfg.cfg_valid = ($urandom_range(0, 2) == 0);
      cfg.cfg_ch    = CHW'($urandom_range(0, NCH - 1));
      r = $urandom_range(0, 7);
      cfg.cfg_target = (r == 0) ? 16'd0 :
                       (r == 1) ? W'(65535 - $urandom_range(0, 300)) : W'($urandom_range(1, 2000));
      cfg.cfg_step  = ($urandom_range(0, 3) == 0) ? 8'd0 : STEP_W'($urandom_range(1, 255));
      step();
      for (int i = 0; i < NCH; i++) begin
        e_rst[i] = m_stop[i];
        e_at[i]  = m_at[i];
        n_checks++;
        if (dut_hp(i) !== m_cur[i]) begin n_fail++; $display("FAIL rnd_div_in[%0d] k=%0d: got %0d want %0d", i, k, dut_hp(i), m_cur[i]); end
      end
      n_checks++; if (div_rst !== e_rst) begin n_fail++; $display("FAIL rnd_div_rst k=%0d: got %b want %b", k, div_rst, e_rst); end
      n_checks++; if (at_target !== e_at) begin n_fail++; $display("FAIL rnd_at_target k=%0d: got %b want %b", k, at_target, e_at); end
      n_checks++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy k=%0d: got %b want %b", k, busy, exp_busy()); end
      n_checks++; if (cfg.cfg_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready k=%0d: got %b want %b", k, cfg.cfg_ready, exp_ready()); end
    end
    cfg.cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_jump();
    test_ramp_down();
    test_saturate();
    test_handshake();
    test_back_to_back();
    test_stop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
